// File: rtl/decoder_scan.sv
// Registered N-to-2**N decoder with continuous-scan and single-sweep modes.
// Scan/sweep hold each index for DWELL enabled cycles before advancing.
module decoder_scan #(
    parameter int N     = 2,
    parameter int DWELL = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic              en,
    input  logic [N-1:0]      din,
    output logic [2**N-1:0]   dout,
    output logic [N-1:0]      idx,
    output logic              step,
    output logic              done
);
    localparam int W  = 2**N;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_TC  = CW'(DWELL - 1);
    localparam logic [N-1:0]  IDX_MAX = '1;

    typedef enum logic [1:0] {
        S_DEC   = 2'd0,
        S_SCAN  = 2'd1,
        S_SWEEP = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    idx_q, idx_d;
    logic [W-1:0]    dout_q, dout_d;
    logic            step_q, step_d;
    logic            done_q, done_d;
    logic            tc;
    logic [N-1:0]    idx_nxt;

    function automatic logic [W-1:0] onehot(input logic [N-1:0] i);
        logic [W-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    assign tc      = (cnt_q == CNT_TC);
    assign idx_nxt = idx_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        dout_d  = '0;
        step_d  = 1'b0;
        done_d  = 1'b0;
        unique case (mode)
            2'b01: begin
                if (state_q != S_SCAN) begin
                    // Entering scan keeps idx so the scan starts where decode left off.
                    state_d = S_SCAN;
                    cnt_d   = '0;
                    dout_d  = en ? onehot(idx_q) : '0;
                end else if (en) begin
                    if (tc) begin
                        cnt_d  = '0;
                        idx_d  = idx_nxt;
                        step_d = 1'b1;
                        dout_d = onehot(idx_nxt);
                    end else begin
                        cnt_d  = cnt_q + 1'b1;
                        dout_d = onehot(idx_q);
                    end
                end
            end
            2'b10: begin
                unique case (state_q)
                    S_SWEEP: begin
                        if (en) begin
                            if (tc && idx_q == IDX_MAX) begin
                                state_d = S_DONE;
                                step_d  = 1'b1;
                                done_d  = 1'b1;
                            end else if (tc) begin
                                cnt_d  = '0;
                                idx_d  = idx_nxt;
                                step_d = 1'b1;
                                dout_d = onehot(idx_nxt);
                            end else begin
                                cnt_d  = cnt_q + 1'b1;
                                dout_d = onehot(idx_q);
                            end
                        end
                    end
                    S_DONE: begin
                        done_d = 1'b1;
                    end
                    default: begin
                        state_d = S_SWEEP;
                        cnt_d   = '0;
                        idx_d   = '0;
                        dout_d  = en ? onehot('0) : '0;
                    end
                endcase
            end
            default: begin
                state_d = S_DEC;
                cnt_d   = '0;
                idx_d   = din;
                dout_d  = en ? onehot(din) : '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_DEC;
            cnt_q   <= '0;
            idx_q   <= '0;
            dout_q  <= '0;
            step_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dout_q  <= dout_d;
            step_q  <= step_d;
            done_q  <= done_d;
        end
    end

    assign dout = dout_q;
    assign idx  = idx_q;
    assign step = step_q;
    assign done = done_q;
endmodule

// File: tb/tb_decoder_scan.sv
// Scoreboard bench for decoder_scan: N=2/DWELL=3 instance plus an N=3/DWELL=1 instance.
module tb_decoder_scan;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] mode_a = 2'b00, mode_b = 2'b00;
    logic       en_a = 1'b0, en_b = 1'b0;
    logic [1:0] din_a = '0;
    logic [2:0] din_b = '0;
    logic [3:0] dout_a;
    logic [7:0] dout_b;
    logic [1:0] idx_a;
    logic [2:0] idx_b;
    logic       step_a, done_a, step_b, done_b;

    decoder_scan #(.N(2), .DWELL(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .mode(mode_a), .en(en_a), .din(din_a),
        .dout(dout_a), .idx(idx_a), .step(step_a), .done(done_a));

    decoder_scan #(.N(3), .DWELL(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .mode(mode_b), .en(en_b), .din(din_b),
        .dout(dout_b), .idx(idx_b), .step(step_b), .done(done_b));

    typedef struct {
        int         vec;
        logic [7:0] dout;
        logic [2:0] idx;
        logic       step;
        logic       done;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int n_vec = 0;
    int n_bad = 0;
    int vec_id = 0;

    function automatic void cmp(string tag, int vec, exp_t e,
                                logic [7:0] d, logic [2:0] i, logic s, logic dn);
        n_vec++;
        if (d !== e.dout || i !== e.idx || s !== e.step || dn !== e.done) begin
            n_bad++;
            $display("FAIL %s vec%0d: got dout=%h idx=%0d step=%b done=%b, want dout=%h idx=%0d step=%b done=%b",
                     tag, vec, d, i, s, dn, e.dout, e.idx, e.step, e.done);
        end
    endfunction

    // Monitors: each cycle's result is checked one step after the active edge.
    always @(posedge clk) begin
        #1;
        if (q_a.size() > 0) begin
            exp_t e;
            e = q_a.pop_front();
            cmp("dutA", e.vec, e, {4'b0, dout_a}, {1'b0, idx_a}, step_a, done_a);
        end
    end

    always @(posedge clk) begin
        #1;
        if (q_b.size() > 0) begin
            exp_t e;
            e = q_b.pop_front();
            cmp("dutB", e.vec, e, dout_b, idx_b, step_b, done_b);
        end
    end

    task automatic cyc_a(input logic [1:0] m, input logic e, input logic [1:0] d,
                         input logic [3:0] xd, input logic [1:0] xi,
                         input logic xs, input logic xdn);
        exp_t x;
        @(negedge clk);
        mode_a = m; en_a = e; din_a = d;
        x.vec = vec_id++; x.dout = {4'b0, xd}; x.idx = {1'b0, xi}; x.step = xs; x.done = xdn;
        q_a.push_back(x);
    endtask

    task automatic cyc_b(input logic [1:0] m, input logic e, input logic [2:0] d,
                         input logic [7:0] xd, input logic [2:0] xi, input logic xs);
        exp_t x;
        @(negedge clk);
        mode_b = m; en_b = e; din_b = d;
        x.vec = vec_id++; x.dout = xd; x.idx = xi; x.step = xs; x.done = 1'b0;
        q_b.push_back(x);
    endtask

    task automatic check_zero(string tag);
        exp_t z;
        z.vec = vec_id++; z.dout = '0; z.idx = '0; z.step = 1'b0; z.done = 1'b0;
        cmp({tag, "_A"}, z.vec, z, {4'b0, dout_a}, {1'b0, idx_a}, step_a, done_a);
        cmp({tag, "_B"}, z.vec, z, dout_b, idx_b, step_b, done_b);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((q_a.size() > 0 || q_b.size() > 0) && guard < 20) begin
            @(posedge clk); #2; guard++;
        end
        if (q_a.size() > 0 || q_b.size() > 0) begin
            n_vec++; n_bad++;
            $display("FAIL drain: %0d/%0d expectations left, want 0", q_a.size(), q_b.size());
            q_a.delete(); q_b.delete();
        end
    endtask

    initial begin
        #2;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Decode, including en=0 and mode 11
        cyc_a(2'b00, 1, 2'd0, 4'b0001, 2'd0, 0, 0);
        cyc_a(2'b00, 1, 2'd1, 4'b0010, 2'd1, 0, 0);
        cyc_a(2'b00, 1, 2'd2, 4'b0100, 2'd2, 0, 0);
        cyc_a(2'b00, 1, 2'd3, 4'b1000, 2'd3, 0, 0);
        cyc_a(2'b00, 0, 2'd2, 4'b0000, 2'd2, 0, 0);
        cyc_a(2'b11, 1, 2'd1, 4'b0010, 2'd1, 0, 0);
        cyc_a(2'b00, 1, 2'd3, 4'b1000, 2'd3, 0, 0);

        // Scan from idx 3: three cycles of 1000, then wrap to 0001
        cyc_a(2'b01, 1, 2'd0, 4'b1000, 2'd3, 0, 0);
        cyc_a(2'b01, 1, 2'd0, 4'b1000, 2'd3, 0, 0);
        cyc_a(2'b01, 1, 2'd0, 4'b1000, 2'd3, 0, 0);
        cyc_a(2'b01, 1, 2'd0, 4'b0001, 2'd0, 1, 0);
        cyc_a(2'b01, 1, 2'd0, 4'b0001, 2'd0, 0, 0);
        cyc_a(2'b01, 1, 2'd0, 4'b0001, 2'd0, 0, 0);
        cyc_a(2'b01, 1, 2'd0, 4'b0010, 2'd1, 1, 0);
        cyc_a(2'b01, 1, 2'd0, 4'b0010, 2'd1, 0, 0);
        cyc_a(2'b01, 1, 2'd0, 4'b0010, 2'd1, 0, 0);
        cyc_a(2'b01, 1, 2'd0, 4'b0100, 2'd2, 1, 0);
        cyc_a(2'b01, 1, 2'd0, 4'b0100, 2'd2, 0, 0);
        cyc_a(2'b01, 1, 2'd0, 4'b0100, 2'd2, 0, 0);
        cyc_a(2'b01, 1, 2'd0, 4'b1000, 2'd3, 1, 0);
        cyc_a(2'b01, 1, 2'd0, 4'b1000, 2'd3, 0, 0);
        cyc_a(2'b01, 1, 2'd0, 4'b1000, 2'd3, 0, 0);
        cyc_a(2'b01, 1, 2'd0, 4'b0001, 2'd0, 1, 0);
        cyc_a(2'b01, 1, 2'd0, 4'b0001, 2'd0, 0, 0);

        // Freeze at cnt=1 for 5 cycles, then advance after 2 enabled cycles
        repeat (5) cyc_a(2'b01, 0, 2'd0, 4'b0000, 2'd0, 0, 0);
        cyc_a(2'b01, 1, 2'd0, 4'b0001, 2'd0, 0, 0);
        cyc_a(2'b01, 1, 2'd0, 4'b0010, 2'd1, 1, 0);

        // Full sweep to done, hold, then exit via decode
        cyc_a(2'b10, 1, 2'd0, 4'b0001, 2'd0, 0, 0);
        cyc_a(2'b10, 1, 2'd0, 4'b0001, 2'd0, 0, 0);
        cyc_a(2'b10, 1, 2'd0, 4'b0001, 2'd0, 0, 0);
        cyc_a(2'b10, 1, 2'd0, 4'b0010, 2'd1, 1, 0);
        cyc_a(2'b10, 1, 2'd0, 4'b0010, 2'd1, 0, 0);
        cyc_a(2'b10, 1, 2'd0, 4'b0010, 2'd1, 0, 0);
        cyc_a(2'b10, 1, 2'd0, 4'b0100, 2'd2, 1, 0);
        cyc_a(2'b10, 1, 2'd0, 4'b0100, 2'd2, 0, 0);
        cyc_a(2'b10, 1, 2'd0, 4'b0100, 2'd2, 0, 0);
        cyc_a(2'b10, 1, 2'd0, 4'b1000, 2'd3, 1, 0);
        cyc_a(2'b10, 1, 2'd0, 4'b1000, 2'd3, 0, 0);
        cyc_a(2'b10, 1, 2'd0, 4'b1000, 2'd3, 0, 0);
        cyc_a(2'b10, 1, 2'd0, 4'b0000, 2'd3, 1, 1);
        cyc_a(2'b10, 1, 2'd0, 4'b0000, 2'd3, 0, 1);
        cyc_a(2'b10, 0, 2'd0, 4'b0000, 2'd3, 0, 1);
        cyc_a(2'b10, 1, 2'd0, 4'b0000, 2'd3, 0, 1);
        cyc_a(2'b00, 1, 2'd2, 4'b0100, 2'd2, 0, 0);

        // Mode change at terminal count wins: sweep -> scan keeps idx, no step
        cyc_a(2'b10, 1, 2'd0, 4'b0001, 2'd0, 0, 0);
        cyc_a(2'b10, 1, 2'd0, 4'b0001, 2'd0, 0, 0);
        cyc_a(2'b10, 1, 2'd0, 4'b0001, 2'd0, 0, 0);
        cyc_a(2'b01, 1, 2'd0, 4'b0001, 2'd0, 0, 0);

        // Sweep with an enable gap, then async reset between edges
        cyc_a(2'b10, 1, 2'd0, 4'b0001, 2'd0, 0, 0);
        cyc_a(2'b10, 0, 2'd0, 4'b0000, 2'd0, 0, 0);
        cyc_a(2'b10, 0, 2'd0, 4'b0000, 2'd0, 0, 0);
        cyc_a(2'b10, 1, 2'd0, 4'b0001, 2'd0, 0, 0);
        cyc_a(2'b10, 1, 2'd0, 4'b0001, 2'd0, 0, 0);
        cyc_a(2'b10, 1, 2'd0, 4'b0010, 2'd1, 1, 0);
        cyc_a(2'b10, 1, 2'd0, 4'b0010, 2'd1, 0, 0);
        drain();
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        @(negedge clk);
        mode_a = 2'b00; din_a = 2'd2; en_a = 1'b1;
        rst_n = 1'b1;
        cyc_a(2'b00, 1, 2'd2, 4'b0100, 2'd2, 0, 0);
        cyc_a(2'b00, 1, 2'd1, 4'b0010, 2'd1, 0, 0);
        drain();

        // N=3, DWELL=1: scan walks one index per cycle with step held high
        cyc_b(2'b00, 1, 3'd0, 8'h01, 3'd0, 0);
        cyc_b(2'b01, 1, 3'd0, 8'h01, 3'd0, 0);
        cyc_b(2'b01, 1, 3'd0, 8'h02, 3'd1, 1);
        cyc_b(2'b01, 1, 3'd0, 8'h04, 3'd2, 1);
        cyc_b(2'b01, 1, 3'd0, 8'h08, 3'd3, 1);
        cyc_b(2'b01, 1, 3'd0, 8'h10, 3'd4, 1);
        cyc_b(2'b01, 1, 3'd0, 8'h20, 3'd5, 1);
        cyc_b(2'b01, 1, 3'd0, 8'h40, 3'd6, 1);
        cyc_b(2'b01, 1, 3'd0, 8'h80, 3'd7, 1);
        cyc_b(2'b01, 1, 3'd0, 8'h01, 3'd0, 1);
        cyc_b(2'b01, 0, 3'd0, 8'h00, 3'd0, 0);
        cyc_b(2'b01, 1, 3'd0, 8'h02, 3'd1, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
